// File: rtl/opc7_sram8_bridge_pkg.sv
// Shared opc7 bus-stage definitions: FSM encoding, counter widths and byte-lane helper.
package opc7_sram8_bridge_pkg;

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StBeat   = 2'd1,
        StIoWait = 2'd2,
        StDone   = 2'd3
    } bus_state_e;

    localparam int unsigned PhaseW = 4;
    localparam int unsigned BeatW  = 2;
    localparam int unsigned TmoW   = 8;

    localparam logic [BeatW-1:0] LastBeat = 2'd3;

    function automatic logic [7:0] lane_byte(input logic [31:0] word, input logic [1:0] lane);
        return word[{lane, 3'b000} +: 8];
    endfunction

endpackage

// File: rtl/opc7_sram8_bridge.sv
// opc7 downstream bus stage: 32-bit CPU cycles to 4 little-endian byte beats on an 8-bit
// async SRAM, or a single req/ack I/O transfer, stalling the core via cpu_clken.
module opc7_sram8_bridge
    import opc7_sram8_bridge_pkg::*;
#(
    parameter int unsigned WAIT_STATES = 1,
    parameter int unsigned IO_TIMEOUT  = 255
) (
    input  logic        clk,
    input  logic        reset_b,
    input  logic [19:0] cpu_address,
    input  logic [31:0] cpu_dout,
    input  logic        cpu_rnw,
    input  logic        cpu_vpa,
    input  logic        cpu_vda,
    input  logic        cpu_vio,
    output logic [31:0] cpu_din,
    output logic        cpu_clken,
    output logic [21:0] sram_addr,
    output logic [7:0]  sram_wdata,
    input  logic [7:0]  sram_rdata,
    output logic        sram_ce_b,
    output logic        sram_oe_b,
    output logic        sram_we_b,
    output logic        sram_drive_b,
    output logic        io_req,
    output logic        io_rnw,
    output logic [19:0] io_addr,
    output logic [31:0] io_wdata,
    input  logic [31:0] io_rdata,
    input  logic        io_ack
);

    // A beat is one setup cycle (strobe_q=0) followed by WAIT_STATES+1 strobe cycles, counted
    // by phase_q from 0; the separate flag keeps the 4-bit counter sufficient for 15 wait states.
    localparam logic [PhaseW-1:0] LastPhase = PhaseW'(WAIT_STATES);
    localparam logic [TmoW-1:0]   LastTmo   = TmoW'(IO_TIMEOUT - 1);

    bus_state_e        state_q, state_d;
    logic [19:0]       addr_q, addr_d;
    logic [31:0]       data_q, data_d;
    logic              rnw_q, rnw_d;
    logic [BeatW-1:0]  beat_q, beat_d;
    logic [PhaseW-1:0] phase_q, phase_d;
    logic              strobe_q, strobe_d;
    logic [TmoW-1:0]   tmo_q, tmo_d;
    logic [31:0]       rd_q, rd_d;
    logic [31:0]       din_q, din_d;

    logic access, mem_cyc, strobe_on;

    assign mem_cyc = cpu_vpa | cpu_vda;
    assign access  = mem_cyc | cpu_vio;

    always_ff @(posedge clk) begin
        if (!reset_b) begin
            state_q  <= StIdle;
            addr_q   <= '0;
            data_q   <= '0;
            rnw_q    <= 1'b1;
            beat_q   <= '0;
            phase_q  <= '0;
            strobe_q <= 1'b0;
            tmo_q    <= '0;
            rd_q     <= '0;
            din_q    <= '0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            data_q   <= data_d;
            rnw_q    <= rnw_d;
            beat_q   <= beat_d;
            phase_q  <= phase_d;
            strobe_q <= strobe_d;
            tmo_q    <= tmo_d;
            rd_q     <= rd_d;
            din_q    <= din_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        data_d   = data_q;
        rnw_d    = rnw_q;
        beat_d   = beat_q;
        phase_d  = phase_q;
        strobe_d = strobe_q;
        tmo_d    = tmo_q;
        rd_d     = rd_q;
        din_d    = din_q;
        unique case (state_q)
            StIdle: begin
                if (access) begin
                    addr_d = cpu_address;
                    data_d = cpu_dout;
                    rnw_d  = cpu_rnw;
                end
                if (mem_cyc) begin
                    beat_d   = '0;
                    phase_d  = '0;
                    strobe_d = 1'b0;
                    state_d  = StBeat;
                end else if (cpu_vio) begin
                    tmo_d   = '0;
                    state_d = StIoWait;
                end
            end
            StBeat: begin
                if (!strobe_q) begin
                    strobe_d = 1'b1;
                    phase_d  = '0;
                end else if (phase_q == LastPhase) begin
                    strobe_d = 1'b0;
                    phase_d  = '0;
                    if (rnw_q) rd_d[{beat_q, 3'b000} +: 8] = sram_rdata;
                    if (beat_q == LastBeat) begin
                        // cpu_din only changes once the whole word is in
                        if (rnw_q) din_d = rd_d;
                        state_d = StDone;
                    end else begin
                        beat_d = beat_q + 2'd1;
                    end
                end else begin
                    phase_d = phase_q + 4'd1;
                end
            end
            StIoWait: begin
                if (io_ack) begin
                    if (rnw_q) din_d = io_rdata;
                    state_d = StDone;
                end else if (tmo_q == LastTmo) begin
                    if (rnw_q) din_d = 32'hFFFF_FFFF;
                    state_d = StDone;
                end else begin
                    tmo_d = tmo_q + 8'd1;
                end
            end
            StDone: state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        strobe_on    = (state_q == StBeat) && strobe_q;
        cpu_clken    = !reset_b || ((state_q == StIdle) && !access) || (state_q == StDone);
        cpu_din      = din_q;
        sram_addr    = {addr_q, beat_q};
        sram_wdata   = lane_byte(data_q, beat_q);
        sram_ce_b    = (state_q != StBeat);
        sram_oe_b    = !(strobe_on && rnw_q);
        sram_we_b    = !(strobe_on && !rnw_q);
        sram_drive_b = !(strobe_on && !rnw_q);
        io_req       = (state_q == StIoWait);
        io_rnw       = rnw_q;
        io_addr      = addr_q;
        io_wdata     = data_q;
    end

endmodule
